// File: rtl/d_mem_access.sv
// Single-port data memory with sized, aligned loads/stores and a one-entry
// registered response buffer. Faulted accesses have no effect on memory and are counted.
module d_mem_access #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 13,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_arstn,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_unsigned,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic [15:0]           o_err_count
);

   localparam int unsigned NB     = DATA_WIDTH / 8;
   localparam int          OFF_W  = $clog2(NB);
   localparam int          IDX_W  = ADDR_WIDTH - OFF_W;
   localparam int          MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state, state_next;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [OFF_W-1:0]      offset;
   logic [IDX_W-1:0]      word_idx;
   logic [31:0]           word_ext;
   logic [MEM_AW-1:0]     mem_idx;
   logic                  in_range;
   logic                  misaligned;
   logic                  bad_size;
   logic                  fault;
   logic                  accept;
   logic                  handoff;
   logic [7:0]            size_mask;
   logic [NB-1:0]         byte_en;
   logic [DATA_WIDTH-1:0] wdata_sh;
   logic [DATA_WIDTH-1:0] rd_sh;
   logic [DATA_WIDTH-1:0] ext_mask;
   logic                  sign_bit;
   logic [DATA_WIDTH-1:0] load_data;

   assign offset   = i_req_addr[OFF_W-1:0];
   assign word_idx = i_req_addr[ADDR_WIDTH-1:OFF_W];
   assign word_ext = 32'(word_idx);
   assign mem_idx  = word_ext[MEM_AW-1:0];
   assign in_range = word_ext < 32'(MEM_DEPTH);
   assign bad_size = (i_req_size == 2'd3) && (NB < 8);
   assign fault    = misaligned || bad_size || !in_range;

   assign o_req_ready = !o_rsp_valid || i_rsp_ready;
   assign accept      = i_req_valid && o_req_ready;
   assign handoff     = o_rsp_valid && i_rsp_ready;

   always_comb begin
      misaligned = 1'b0;
      size_mask  = 8'h01;
      case (i_req_size)
         2'd0: begin misaligned = 1'b0;         size_mask = 8'h01; end
         2'd1: begin misaligned = offset[0];    size_mask = 8'h03; end
         2'd2: begin misaligned = |offset[1:0]; size_mask = 8'h0F; end
         default: begin misaligned = |offset;   size_mask = 8'hFF; end
      endcase
   end

   assign byte_en  = size_mask[NB-1:0] << offset;
   assign wdata_sh = i_req_wdata << {offset, 3'b000};
   assign rd_sh    = mem[mem_idx] >> {offset, 3'b000};

   // Extension is done by masking rather than replication so the same code
   // serves both 32- and 64-bit words (no zero-width replications).
   always_comb begin
      ext_mask = '0;
      sign_bit = 1'b0;
      case (i_req_size)
         2'd0: begin ext_mask[7:0]  = '1; sign_bit = rd_sh[7];  end
         2'd1: begin ext_mask[15:0] = '1; sign_bit = rd_sh[15]; end
         2'd2: begin ext_mask[31:0] = '1; sign_bit = rd_sh[31]; end
         default: begin ext_mask = '1;    sign_bit = 1'b0;      end
      endcase
      load_data = rd_sh & ext_mask;
      if (sign_bit && !i_req_unsigned)
         load_data = load_data | ~ext_mask;
   end

   always_ff @(posedge i_clk) begin
      if (i_arstn && accept && !fault && i_req_we) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (byte_en[b])
               mem[mem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn)
         state <= EMPTY;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (accept) state_next = FULL;
         FULL:    if (handoff && !accept) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      o_rsp_valid = (state == FULL);
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
         o_err_count <= '0;
      end else if (accept) begin
         o_rsp_err   <= fault;
         o_rsp_rdata <= (fault || i_req_we) ? '0 : load_data;
         if (fault && (o_err_count != 16'hFFFF))
            o_err_count <= o_err_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_d_mem_access.sv
// Directed bench for d_mem_access: sized access, faults, stall/streaming, async reset.
module tb_d_mem_access;

   logic        clk = 1'b0;
   logic        arstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [13:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic [15:0] err_count;

   int checks = 0;
   int passed = 0;
   int exp_errs = 0;

   // ADDR_WIDTH widened so that MEM_DEPTH*8 is representable on the address bus.
   d_mem_access #(.DATA_WIDTH(64), .ADDR_WIDTH(14), .MEM_DEPTH(1024)) dut (
      .i_clk(clk), .i_arstn(arstn),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
      .i_req_unsigned(req_unsigned), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_err_count(err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic drive(input logic we, input logic [13:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] wdata);
      req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
      req_valid = 1'b1;
   endtask

   task automatic single(input logic we, input logic [13:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata);
      @(negedge clk);
      drive(we, addr, size, uns, wdata);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      arstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      drive(1'b0, 14'h0, 2'd0, 1'b0, 64'h0);
      req_valid = 1'b0;
      #2;
      checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rsp_valid); else passed++;
      checks++; if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", rsp_err); else passed++;
      checks++; if (rsp_rdata !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); else passed++;
      checks++; if (err_count !== 16'h0) $display("FAIL reset_count: got %h expected 0", err_count); else passed++;
      checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else passed++;
      repeat (2) @(negedge clk);
      arstn = 1'b1;
   endtask

   task automatic test_dword;
      single(1'b1, 14'h10, 2'd3, 1'b0, 64'h1122334455667788);
      checks++; if (rsp_valid !== 1'b1) $display("FAIL st_dword_valid: got %b expected 1", rsp_valid); else passed++;
      checks++; if (rsp_err !== 1'b0) $display("FAIL st_dword_err: got %b expected 0", rsp_err); else passed++;
      checks++; if (rsp_rdata !== 64'h0) $display("FAIL st_dword_rdata: got %h expected 0", rsp_rdata); else passed++;
      single(1'b0, 14'h10, 2'd3, 1'b0, 64'h0);
      checks++; if (rsp_rdata !== 64'h1122334455667788) $display("FAIL ld_dword: got %h expected 1122334455667788", rsp_rdata); else passed++;
      checks++; if (rsp_err !== 1'b0) $display("FAIL ld_dword_err: got %b expected 0", rsp_err); else passed++;
   endtask

   task automatic test_subword;
      single(1'b1, 14'h13, 2'd0, 1'b0, 64'h000000000000CDAB);
      checks++; if (rsp_err !== 1'b0) $display("FAIL st_byte_err: got %b expected 0", rsp_err); else passed++;
      single(1'b0, 14'h13, 2'd0, 1'b0, 64'h0);
      checks++; if (rsp_rdata !== 64'hFFFFFFFFFFFFFFAB) $display("FAIL ld_byte_s: got %h expected ffffffffffffffab", rsp_rdata); else passed++;
      single(1'b0, 14'h12, 2'd1, 1'b1, 64'h0);
      checks++; if (rsp_rdata !== 64'h000000000000AB66) $display("FAIL ld_half_u: got %h expected 000000000000ab66", rsp_rdata); else passed++;
      single(1'b0, 14'h10, 2'd3, 1'b0, 64'h0);
      checks++; if (rsp_rdata !== 64'h11223344AB667788) $display("FAIL byte_merge: got %h expected 11223344ab667788", rsp_rdata); else passed++;
   endtask

   task automatic test_misalign;
      single(1'b0, 14'h12, 2'd2, 1'b0, 64'h0);
      exp_errs++;
      checks++; if (rsp_err !== 1'b1) $display("FAIL mis_ld_err: got %b expected 1", rsp_err); else passed++;
      checks++; if (rsp_rdata !== 64'h0) $display("FAIL mis_ld_rdata: got %h expected 0", rsp_rdata); else passed++;
      checks++; if (err_count !== 16'd1) $display("FAIL mis_ld_count: got %0d expected 1", err_count); else passed++;
      single(1'b1, 14'h11, 2'd1, 1'b0, 64'h000000000000FFFF);
      exp_errs++;
      checks++; if (rsp_err !== 1'b1) $display("FAIL mis_st_err: got %b expected 1", rsp_err); else passed++;
      checks++; if (err_count !== 16'd2) $display("FAIL mis_st_count: got %0d expected 2", err_count); else passed++;
      single(1'b0, 14'h10, 2'd3, 1'b0, 64'h0);
      checks++; if (rsp_rdata !== 64'h11223344AB667788) $display("FAIL mis_unchanged: got %h expected 11223344ab667788", rsp_rdata); else passed++;
      checks++; if (rsp_err !== 1'b0) $display("FAIL mis_after_err: got %b expected 0", rsp_err); else passed++;
   endtask

   task automatic test_range;
      int n;
      single(1'b1, 14'h1FF8, 2'd3, 1'b0, 64'hA5A500005A5AFFFF);
      checks++; if (rsp_err !== 1'b0) $display("FAIL last_st_err: got %b expected 0", rsp_err); else passed++;
      single(1'b0, 14'h1FF8, 2'd3, 1'b0, 64'h0);
      checks++; if (rsp_rdata !== 64'hA5A500005A5AFFFF) $display("FAIL last_ld: got %h expected a5a500005a5affff", rsp_rdata); else passed++;
      single(1'b0, 14'h2000, 2'd3, 1'b0, 64'h0);
      exp_errs++;
      checks++; if (rsp_err !== 1'b1) $display("FAIL oor_err: got %b expected 1", rsp_err); else passed++;
      checks++; if (rsp_rdata !== 64'h0) $display("FAIL oor_rdata: got %h expected 0", rsp_rdata); else passed++;
      checks++; if (err_count !== 16'd3) $display("FAIL oor_count: got %0d expected 3", err_count); else passed++;
      single(1'b1, 14'h1FFC, 2'd3, 1'b0, 64'h0);
      exp_errs++;
      checks++; if (rsp_err !== 1'b1) $display("FAIL dword_mis_err: got %b expected 1", rsp_err); else passed++;
      checks++; if (err_count !== 16'd4) $display("FAIL dword_mis_count: got %0d expected 4", err_count); else passed++;
      // Stream faulting requests one per cycle up to and past saturation.
      n = 65535 - exp_errs;
      @(negedge clk);
      drive(1'b0, 14'h2000, 2'd3, 1'b0, 64'h0);
      rsp_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      checks++; if (err_count !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", err_count); else passed++;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (err_count !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", err_count); else passed++;
      checks++; if (rsp_err !== 1'b1) $display("FAIL sat_err: got %b expected 1", rsp_err); else passed++;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) $display("FAIL drain_valid: got %b expected 0", rsp_valid); else passed++;
      exp_errs = 65535;
   endtask

   task automatic test_back_to_back;
      logic [13:0] va [6];
      logic [1:0]  vs [6];
      logic        vu [6];
      logic [63:0] ve [6];
      va = '{14'h10, 14'h10, 14'h10, 14'h14, 14'h17, 14'h16};
      vs = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
      vu = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      ve = '{64'h88, 64'h7788, 64'hFFFFFFFFAB667788, 64'h11223344, 64'h11, 64'h1122};
      // Store then load of the same word on consecutive edges.
      @(negedge clk);
      drive(1'b1, 14'h20, 2'd3, 1'b0, 64'h0123456789ABCDEF);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0) $display("FAIL raw_store: got %b/%h expected 1/0", rsp_valid, rsp_rdata); else passed++;
      @(negedge clk);
      drive(1'b0, 14'h20, 2'd3, 1'b0, 64'h0);
      @(posedge clk); #1;
      checks++; if (rsp_rdata !== 64'h0123456789ABCDEF) $display("FAIL raw_load: got %h expected 0123456789abcdef", rsp_rdata); else passed++;
      req_valid = 1'b0;
      // Load, then hold the consumer off for five cycles with a new request waiting.
      single(1'b0, 14'h10, 2'd3, 1'b0, 64'h0);
      rsp_ready = 1'b0;
      drive(1'b0, va[0], vs[0], vu[0], 64'h0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++; if (rsp_valid !== 1'b1) $display("FAIL stall_valid%0d: got %b expected 1", c, rsp_valid); else passed++;
         checks++; if (rsp_rdata !== 64'h11223344AB667788) $display("FAIL stall_rdata%0d: got %h expected 11223344ab667788", c, rsp_rdata); else passed++;
         checks++; if (req_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b expected 0", c, req_ready); else passed++;
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(1'b0, va[i], vs[i], vu[i], 64'h0);
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== ve[i])
            $display("FAIL stream%0d: got %b/%b/%h expected 1/0/%h", i, rsp_valid, rsp_err, rsp_rdata, ve[i]);
         else passed++;
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) $display("FAIL stream_drain: got %b expected 0", rsp_valid); else passed++;
   endtask

   task automatic test_reset_mid;
      single(1'b1, 14'h40, 2'd3, 1'b0, 64'hDEADBEEFCAFEF00D);
      single(1'b0, 14'h40, 2'd3, 1'b0, 64'h0);
      checks++; if (rsp_valid !== 1'b1) $display("FAIL pre_rst_valid: got %b expected 1", rsp_valid); else passed++;
      #2;
      arstn = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", rsp_valid); else passed++;
      checks++; if (err_count !== 16'h0) $display("FAIL mid_rst_count: got %h expected 0", err_count); else passed++;
      checks++; if (rsp_rdata !== 64'h0) $display("FAIL mid_rst_rdata: got %h expected 0", rsp_rdata); else passed++;
      checks++; if (req_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b expected 1", req_ready); else passed++;
      // A store presented across an edge while reset is low must not land.
      drive(1'b1, 14'h40, 2'd3, 1'b0, 64'h0);
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_edge_valid: got %b expected 0", rsp_valid); else passed++;
      @(negedge clk);
      req_valid = 1'b0;
      arstn = 1'b1;
      single(1'b0, 14'h40, 2'd3, 1'b0, 64'h0);
      checks++; if (rsp_rdata !== 64'hDEADBEEFCAFEF00D) $display("FAIL rst_retained: got %h expected deadbeefcafef00d", rsp_rdata); else passed++;
      checks++; if (err_count !== 16'h0) $display("FAIL post_rst_count: got %h expected 0", err_count); else passed++;
   endtask

   initial begin
      test_reset();
      test_dword();
      test_subword();
      test_misalign();
      test_range();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
